ifetch_unit: RTL and testbench

- Fetch initiator for the byte-addressed, little-endian instruction memory, which has a combinational read.
- Owns the PC and drives the memory address every cycle.
- Registers each returned 32-bit word, with its PC, into a one-entry output stage that feeds decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute and faults on misaligned or out-of-range PCs.

---
 rtl/ifetch_unit.sv | 124 ++++++++++++
 tb/tb_ifetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch initiator for a combinational-read, byte-addressed,
// little-endian instruction memory.
//
// Owns the PC and presents it on `address` every cycle. The word returned on
// `ins_in` is captured together with its PC into a one-entry output stage
// that hands instructions to decode over a valid/ready handshake. A redirect
// from execute replaces the PC and flushes the output stage. A misaligned or
// out-of-range PC halts fetch in a FAULT state until a legal redirect arrives.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   address           byte address to memory (the current PC)
//   ins_in            memory read data for `address`
//   redirect_valid/pc redirect request from execute
//   out_valid/ready   handshake to decode
//   out_ins, out_pc   fetched instruction and its byte address
//   fault             fetch halted on an illegal PC
//
// Optional build macro IFETCH_PERF_EN adds fetch_count (captures) and
// stall_count (RUN cycles held by decode backpressure), both wrapping.

module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] address,
    input  logic [31:0] ins_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        fault
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;

    logic w_pc_ok;
    logic w_redirect_ok;
    logic w_slot_free;
    logic w_capture;

    // Legal iff word aligned and the whole word lies inside memory. The
    // bound is checked in 33 bits so a PC near 2^32 cannot wrap into range.
    function automatic logic pc_legal(input logic [31:0] p);
        return (p[1:0] == 2'b00) &&
               (({1'b0, p} + 33'd3) < 33'(MEM_BYTES));
    endfunction

    assign address       = r_pc;
    assign w_pc_ok       = pc_legal(r_pc);
    assign w_redirect_ok = pc_legal(redirect_pc);
    assign w_slot_free   = !out_valid || out_ready;
    assign w_capture     = (r_state == RUN) && !redirect_valid && w_slot_free && w_pc_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            out_valid <= 1'b0;
            out_ins   <= NOP;
            out_pc    <= 32'h0;
            fault     <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid) begin
                        // Redirect flushes the held entry even if decode
                        // takes it this cycle; no capture on this edge.
                        r_pc      <= redirect_pc;
                        out_valid <= 1'b0;
                    end else if (w_slot_free && !w_pc_ok) begin
                        r_state   <= FAULT;
                        out_valid <= 1'b0;
                        fault     <= 1'b1;
                    end else if (w_capture) begin
                        out_ins   <= ins_in;
                        out_pc    <= r_pc;
                        out_valid <= 1'b1;
                        r_pc      <= r_pc + 32'd4;
                    end
                    // else: stalled by decode, everything holds
                end
                FAULT: begin
                    if (redirect_valid && w_redirect_ok) begin
                        r_pc    <= redirect_pc;
                        fault   <= 1'b0;
                        r_state <= RUN;
                    end
                end
                default: r_state <= FAULT;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic w_stall;
    assign w_stall = (r_state == RUN) && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
            stall_count <= 32'h0;
        end else begin
            if (w_capture) fetch_count <= fetch_count + 32'd1;
            if (w_stall)   stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed walk through the fetch/stall/redirect/fault
// scenarios, then randomized redirects and backpressure, all compared every
// cycle against a transaction-level model of the fetch stage.

module tb_ifetch_unit;

    localparam int MEMB = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] ins_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        fault;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    ifetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .ins_in(ins_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
        .out_pc(out_pc), .fault(fault)
`ifdef IFETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory, word-indexed.
    logic [31:0] mem [8];
    assign ins_in = (address < 32'(MEMB)) ? mem[address[4:2]] : 32'hDEADBEEF;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the fetch stage as "a PC, an optional held
    // instruction, and a halted flag".
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_have;
    logic [31:0] m_ins, m_ipc;
    longint      m_fetches, m_stalls;

    function automatic bit legal(input logic [31:0] p);
        return (p % 4 == 0) && (longint'(p) + 3 < longint'(MEMB));
    endfunction

    task automatic m_reset();
        m_pc = 0; m_halted = 0; m_have = 0; m_ins = 32'h13; m_ipc = 0;
        m_fetches = 0; m_stalls = 0;
    endtask

    task automatic m_step(input bit rv, input logic [31:0] rpc, input bit rdy);
        if (m_halted) begin
            if (rv && legal(rpc)) begin m_pc = rpc; m_halted = 0; end
        end else begin
            if (m_have && !rdy) m_stalls++;
            if (rv) begin
                m_pc = rpc; m_have = 0;
            end else if (!m_have || rdy) begin
                if (legal(m_pc)) begin
                    m_ins = mem[m_pc / 4]; m_ipc = m_pc; m_have = 1;
                    m_pc = m_pc + 4; m_fetches++;
                end else begin
                    m_halted = 1; m_have = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(m_have));
        chk({tag, ".fault"}, 32'(fault), 32'(m_halted));
        chk({tag, ".addr"}, address, m_pc);
        chk({tag, ".pc"}, out_pc, m_ipc);
        chk({tag, ".ins"}, out_ins, m_ins);
`ifdef IFETCH_PERF_EN
        chk({tag, ".fcnt"}, fetch_count, 32'(m_fetches));
        chk({tag, ".scnt"}, stall_count, 32'(m_stalls));
`endif
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic cyc(input string tag, input bit rv, input logic [31:0] rpc, input bit rdy);
        redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        m_step(rv, rpc, rdy);
        @(posedge clk); #1;
        chk_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk_model(tag);
        chk({tag, ".nop"}, out_ins, 32'h00000013);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        mem[0] = 32'h00400093; mem[1] = 32'h00800113; mem[2] = 32'h0020CC63;
        mem[3] = 32'h00308213; mem[4] = 32'h00410293; mem[5] = 32'h00518313;
        mem[6] = 32'h00620393; mem[7] = 32'h00218193;
        rst_n = 1'b0; redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        m_reset();
        #12;
        chk_model("reset");
        chk("reset.nop", out_ins, 32'h00000013);
        @(negedge clk); rst_n = 1'b1;

        // Back-to-back fetch from reset.
        cyc("run0", 0, 0, 1); chk("run0.pc", out_pc, 0); chk("run0.addr", address, 4);
        cyc("run1", 0, 0, 1); chk("run1.pc", out_pc, 4); chk("run1.addr", address, 8);
        // Decode stalls for 3 cycles on out_pc = 4.
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 0, 0, 0);
            chk("stall.ins", out_ins, 32'h00800113);
            chk("stall.addr", address, 8);
        end
`ifdef IFETCH_PERF_EN
        chk("stall.count", stall_count, 3);
`endif
        cyc("rel", 0, 0, 1); chk("rel.pc", out_pc, 8);
        // Redirect to 28 while out_pc = 8.
        cyc("rd28", 1, 28, 1); chk("rd28.valid", 32'(out_valid), 0);
        cyc("rd28b", 0, 0, 1); chk("rd28b.pc", out_pc, 28); chk("rd28b.ins", out_ins, 32'h00218193);
        // Misaligned redirect, then recovery to 12.
        cyc("rd30", 1, 30, 1);
        cyc("rd30b", 0, 0, 1); chk("rd30b.fault", 32'(fault), 1);
        cyc("rd12", 1, 12, 1); chk("rd12.fault", 32'(fault), 0);
        cyc("rd12b", 0, 0, 1); chk("rd12b.pc", out_pc, 12);
        // Run off the end of the 32-byte memory.
        for (int i = 0; i < 4; i++) cyc("tail", 0, 0, 1);
        chk("tail.pc", out_pc, 28);
        cyc("off", 0, 0, 1); chk("off.fault", 32'(fault), 1); chk("off.addr", address, 32);
        cyc("off2", 0, 0, 1); chk("off2.valid", 32'(out_valid), 0);
        // Illegal redirect out of FAULT is ignored.
        cyc("flt_bad", 1, 32'hFFFFFFFC, 1); chk("flt_bad.fault", 32'(fault), 1);

        async_reset("rst_fault");

        // Randomized redirects and backpressure.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 6)       rpc = 32'($urandom_range(0, 7)) * 4;
            else if (r == 6) rpc = 32;
            else if (r == 7) rpc = 32'($urandom_range(0, 31)) | 32'h1;
            else if (r == 8) rpc = 32'hFFFFFFFC;
            else             rpc = $urandom;
            cyc("rnd", $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 9) < 7);
        end

        // Reset in the middle of a stall.
        cyc("pre", 1, 0, 1);
        cyc("pre2", 0, 0, 1);
        cyc("pre3", 0, 0, 0);
        chk("pre3.valid", 32'(out_valid), 1);
        async_reset("rst_stall");
        cyc("post", 0, 0, 1); chk("post.pc", out_pc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
